mem_access_unit: RTL

Multicycle data-memory access unit sitting directly downstream of the multicycle control FSM, between the datapath (address/store-data registers) and the data-memory bus. It turns the control's level-held read/write strobes into a single bus transaction with byte enables, a wait-state handshake and a timeout. It returns sign- or zero-extended load data, and flags misaligned, illegal-size and timed-out accesses. `oBusy` lets the control FSM stall until `oDone`.

---
 rtl/mem_access_unit_pkg.sv | 43 ++++
 rtl/mem_lane_align.sv | 57 +++++
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: funct3 access codes,
// fault codes, FSM state encoding and the access-size legality helper.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    MA_IDLE = 2'b00,
    MA_REQ  = 2'b01,
    MA_DONE = 2'b10,
    MA_HOLD = 2'b11
  } ma_state_e;

  // Stores only have signed-size codes; loads add the two unsigned variants.
  function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
    logic ok;
    if (is_write) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store replication, load lane
// select with sign/zero extension, and misalign/illegal-size detection.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic        is_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] lane_s;

  // Size decode drives every lane function; funct3[2] selects zero extension.
  always_comb begin
    lane_s    = rword >> {addr_lo, 3'b000};
    illegal   = ~f3_legal(is_write, funct3);
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'h0000_0000;
    misalign  = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = funct3[2] ? {24'h00_0000, lane_s[7:0]}
                              : {{24{lane_s[7]}}, lane_s[7:0]};
      end
      2'b01: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = funct3[2] ? {16'h0000, lane_s[15:0]}
                              : {{16{lane_s[15]}}, lane_s[15:0]};
        misalign  = addr_lo[0];
      end
      2'b10: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rword;
        misalign  = (addr_lo != 2'b00);
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0000_0000;
        misalign  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle data-memory access unit: turns level-held load/store strobes into
// one bus transaction with wait states, timeout and fault reporting.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  input  logic [2:0]  iFunct3,
  output logic [31:0] oRData,
  output logic        oDone,
  output logic        oBusy,
  output logic        oFault,
  output logic [1:0]  oFaultCode,
  output logic        oBusReq,
  output logic        oBusWe,
  output logic [31:0] oBusAddr,
  output logic [3:0]  oBusBE,
  output logic [31:0] oBusWData,
  input  logic        iBusAck,
  input  logic [31:0] iBusRData
);

  localparam logic [7:0] TIMEOUT_L = TIMEOUT[7:0];

  ma_state_e   state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        idle_s;
  logic        strobe_s;
  logic        align_we_s;
  logic [2:0]  align_f3_s;
  logic [1:0]  align_lo_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s;
  logic [31:0] rdata_ext_s;
  logic        misalign_s;
  logic        illegal_s;

  // In IDLE the lane logic classifies the incoming request; afterwards it
  // works from the latched copy so load extension uses the accepted access.
  always_comb begin
    idle_s     = (state_q == MA_IDLE);
    strobe_s   = iMemRead | iMemWrite;
    align_we_s = idle_s ? iMemWrite : we_q;
    align_f3_s = idle_s ? iFunct3 : funct3_q;
    align_lo_s = idle_s ? iAddr[1:0] : addr_lo_q;
  end

  mem_lane_align u_lane (
    .is_write  (align_we_s),
    .funct3    (align_f3_s),
    .addr_lo   (align_lo_s),
    .wdata     (iWData),
    .rword     (iBusRData),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .rdata_ext (rdata_ext_s),
    .misalign  (misalign_s),
    .illegal   (illegal_s)
  );

  // Next-state and next-output logic for the access FSM.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    done_d       = 1'b0;
    fault_d      = 1'b0;
    fault_code_d = fault_code_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    case (state_q)
      MA_IDLE: begin
        if (strobe_s) begin
          we_d      = iMemWrite;
          funct3_d  = iFunct3;
          addr_lo_d = iAddr[1:0];
          cnt_d     = 8'd0;
          if (illegal_s || misalign_s) begin
            // Illegal size outranks misalignment; no bus cycle is issued.
            fault_code_d = illegal_s ? FLT_ILLEGAL : FLT_MISALIGN;
            fault_d      = 1'b1;
            done_d       = 1'b1;
            rdata_d      = 32'h0000_0000;
            state_d      = MA_DONE;
          end else begin
            fault_code_d = FLT_NONE;
            bus_req_d    = 1'b1;
            bus_we_d     = iMemWrite;
            bus_addr_d   = {iAddr[31:2], 2'b00};
            bus_be_d     = be_s;
            bus_wdata_d  = wdata_rep_s;
            state_d      = MA_REQ;
          end
        end else begin
          state_d = MA_IDLE;
        end
      end
      MA_REQ: begin
        if (iBusAck) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          done_d    = 1'b1;
          rdata_d   = we_q ? rdata_q : rdata_ext_s;
          state_d   = MA_DONE;
        end else if ((cnt_q + 8'd1) == TIMEOUT_L) begin
          bus_req_d    = 1'b0;
          bus_we_d     = 1'b0;
          done_d       = 1'b1;
          fault_d      = 1'b1;
          fault_code_d = FLT_TIMEOUT;
          rdata_d      = 32'h0000_0000;
          state_d      = MA_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      MA_DONE: begin
        state_d = MA_HOLD;
      end
      MA_HOLD: begin
        if (!strobe_s) begin
          state_d = MA_IDLE;
        end else begin
          state_d = MA_HOLD;
        end
      end
      default: begin
        state_d = MA_IDLE;
      end
    endcase
    busy_d = (state_d != MA_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= MA_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      cnt_q        <= 8'd0;
      rdata_q      <= 32'h0000_0000;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0000_0000;
      bus_be_q     <= 4'b0000;
      bus_wdata_q  <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  assign oRData     = rdata_q;
  assign oDone      = done_q;
  assign oBusy      = busy_q;
  assign oFault     = fault_q;
  assign oFaultCode = fault_code_q;
  assign oBusReq    = bus_req_q;
  assign oBusWe     = bus_we_q;
  assign oBusAddr   = bus_addr_q;
  assign oBusBE     = bus_be_q;
  assign oBusWData  = bus_wdata_q;

endmodule
